// File: rtl/arb_pkg.sv
// Shared constants for the round-robin decode arbiter: requester count,
// index width, default hold limit and FSM state encodings.
package arb_pkg;
  localparam int N_REQ        = 16;
  localparam int IDX_W        = 4;
  localparam int MAX_HOLD_DEF = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
endpackage

// File: rtl/grant_onehot_dec.sv
// Combinational 4-to-16 one-hot decoder with enable; the output is all-zero
// when disabled.
module grant_onehot_dec
  import arb_pkg::*;
(
  input  logic             i_en,
  input  logic [IDX_W-1:0] i_idx,
  output logic [N_REQ-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot = N_REQ'(1) << i_idx;
  end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 16 requesters with registered index and one-hot grant.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module rr_decode_arbiter
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic             timeout
);

  // Handshake: gnt_valid has no ready; the owner keeps the grant by holding
  // its req bit high and hands it back by dropping that bit.

  logic [0:0]       r_state;
  logic             r_valid;
  logic             r_timeout;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_ptr;
  logic [N_REQ-1:0] r_onehot;

  logic             w_found;
  logic [IDX_W-1:0] w_pick;
  logic             w_to_fire;
  logic [0:0]       w_nxt_state;
  logic             w_nxt_valid;
  logic             w_nxt_timeout;
  logic [IDX_W-1:0] w_nxt_idx;
  logic [IDX_W-1:0] w_nxt_ptr;
  logic [N_REQ-1:0] w_nxt_onehot;

  // Rotate so ptr+1 lands on bit 0, take the lowest set bit, then rotate back.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] start;
    logic [N_REQ-1:0] rot;
    logic             found;
    logic [IDX_W-1:0] pos;
    start = p + 1'b1;
    rot   = N_REQ'({r, r} >> start);
    found = 1'b0;
    pos   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        pos   = IDX_W'(k);
      end
    end
    return {found, pos + start};
  endfunction

  assign {w_found, w_pick} = rr_pick(req, r_ptr);

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

  logic [HOLD_W-1:0] r_hold;

  assign w_to_fire = (r_state == ST_GRANT) && req[r_idx] &&
                     (r_hold == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if ((r_state == ST_GRANT) && req[r_idx] && !w_to_fire) begin
      r_hold <= r_hold + 1'b1;
    end else begin
      r_hold <= '0;
    end
  end
`else
  assign w_to_fire = 1'b0;
`endif

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_valid   = r_valid;
    w_nxt_idx     = r_idx;
    w_nxt_ptr     = r_ptr;
    w_nxt_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_nxt_state = ST_GRANT;
          w_nxt_valid = 1'b1;
          w_nxt_idx   = w_pick;
          w_nxt_ptr   = w_pick;
        end
      end
      default: begin
        // ptr is left alone on release so the previous owner sits last in line.
        if (!req[r_idx] || w_to_fire) begin
          w_nxt_state   = ST_IDLE;
          w_nxt_valid   = 1'b0;
          w_nxt_idx     = '0;
          w_nxt_timeout = w_to_fire;
        end
      end
    endcase
  end

  grant_onehot_dec u_dec (
    .i_en     (w_nxt_valid),
    .i_idx    (w_nxt_idx),
    .o_onehot (w_nxt_onehot)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_ptr     <= IDX_W'(N_REQ - 1);
      r_onehot  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_valid   <= w_nxt_valid;
      r_idx     <= w_nxt_idx;
      r_ptr     <= w_nxt_ptr;
      r_onehot  <= w_nxt_onehot;
      r_timeout <= w_nxt_timeout;
    end
  end

  assign gnt_valid  = r_valid;
  assign gnt_idx    = r_idx;
  assign gnt_onehot = r_onehot;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed bench for rr_decode_arbiter: reset, idle, full rotation, wrap order,
// mid-grant reset, wrap-to-self and hold/timeout behaviour (ARB_TIMEOUT_EN aware).
module tb_rr_decode_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        gnt_valid;
  logic [3:0]  gnt_idx;
  logic [15:0] gnt_onehot;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;
  bit inv_en   = 1'b0;

  rr_decode_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .timeout    (timeout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_gnt(input string tag, input logic v, input logic [3:0] idx);
    logic [15:0] oh;
    oh = v ? (16'h0001 << idx) : 16'h0000;
    check({tag, "_valid"}, {31'd0, gnt_valid}, {31'd0, v});
    check({tag, "_idx"}, {28'd0, gnt_idx}, {28'd0, idx});
    check({tag, "_onehot"}, {16'd0, gnt_onehot}, {16'd0, oh});
  endtask

  // Owner drops its bit for one edge, then base is restored; next grant expected.
  task automatic release_owner(input logic [3:0] idx, input logic [15:0] base,
                               input logic [3:0] nxt);
    req = base & ~(16'h0001 << idx);
    tick();
    exp_gnt("rel", 1'b0, 4'd0);
    check("rel_state", {31'd0, dut.r_state}, 32'd0);
    req = base;
    tick();
    exp_gnt("nxt", 1'b1, nxt);
  endtask

  // Output invariants every cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (inv_en) begin
      logic [15:0] oh;
      oh = gnt_valid ? (16'h0001 << gnt_idx) : 16'h0000;
      check("inv_onehot", {16'd0, gnt_onehot}, {16'd0, oh});
      check("inv_popcnt", {31'd0, ($countones(gnt_onehot) <= 1)}, 32'd1);
      if (!gnt_valid) check("inv_idx0", {28'd0, gnt_idx}, 32'd0);
`ifndef ARB_TIMEOUT_EN
      check("inv_timeout0", {31'd0, timeout}, 32'd0);
`endif
    end
  end

  initial begin
    logic [3:0] cur;
    rst_n = 1'b0;
    req   = 16'hFFFF;

    // 1: reset with all requests pending
    tick();
    inv_en = 1'b1;
    tick();
    exp_gnt("rst", 1'b0, 4'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_state", {31'd0, dut.r_state}, 32'd0);
    rst_n = 1'b1;
    tick();
    exp_gnt("first", 1'b1, 4'd0);

    // 2: no requests for 20 cycles
    req = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_gnt("idle", 1'b0, 4'd0);
      check("idle_state", {31'd0, dut.r_state}, 32'd0);
    end

    // 3: full rotation from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req   = 16'hFFFF;
    tick();
    exp_gnt("rot0", 1'b1, 4'd0);
    cur = 4'd0;
    for (int g = 0; g < 17; g++) begin
      for (int h = 0; h < 2; h++) begin
        tick();
        exp_gnt("hold", 1'b1, cur);
      end
      if (g < 16) begin
        release_owner(cur, 16'hFFFF, cur + 4'd1);
        cur = cur + 4'd1;
      end
    end

    // 4: wrap order after owner 5
    release_owner(4'd0, 16'h0020, 4'd5);
    release_owner(4'd5, 16'h8021, 4'd15);
    release_owner(4'd15, 16'h8021, 4'd0);
    release_owner(4'd0, 16'h8021, 4'd5);

    // 5: reset mid-grant of owner 3
    release_owner(4'd5, 16'h0008, 4'd3);
    rst_n = 1'b0;
    tick();
    exp_gnt("midrst", 1'b0, 4'd0);
    check("midrst_timeout", {31'd0, timeout}, 32'd0);
    rst_n = 1'b1;
    req   = 16'hFFFF;
    tick();
    exp_gnt("postrst", 1'b1, 4'd0);

    // only requester 15 pending with ptr=15 grants 15 again
    release_owner(4'd0, 16'h8000, 4'd15);
    release_owner(4'd15, 16'h8000, 4'd15);

    // 6: requester 9 held alone
    release_owner(4'd15, 16'h0200, 4'd9);
    check("hold9_to", {31'd0, timeout}, 32'd0);
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c < 8; c++) begin
      tick();
      exp_gnt("hold9", 1'b1, 4'd9);
      check("hold9_to", {31'd0, timeout}, 32'd0);
    end
    tick();
    exp_gnt("to_rel", 1'b0, 4'd0);
    check("to_pulse", {31'd0, timeout}, 32'd1);
    tick();
    exp_gnt("to_regnt", 1'b1, 4'd9);
    check("to_after", {31'd0, timeout}, 32'd0);
`else
    for (int c = 1; c < 24; c++) begin
      tick();
      exp_gnt("hold9", 1'b1, 4'd9);
      check("hold9_to", {31'd0, timeout}, 32'd0);
    end
`endif

    inv_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
